// File: rtl/pattern_seq_pkg.sv
// Shared types and constants for the pattern_seq stimulus sequencer.
package pattern_seq_pkg;

    localparam int PATTERN_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Counter must represent HOLD_CYCLES-1; never narrower than one bit.
    function automatic int hold_cnt_w(input int hold_cycles);
        return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
    endfunction

endpackage

// File: rtl/pattern_seq_hold_timer.sv
// Loadable down-counter that flags expiry when it reaches zero.
module hold_timer
    import pattern_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = hold_cnt_w(HOLD_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Load wins over counting so a new pattern always starts with a full hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/pattern_seq.sv
// Clocked 3-bit stimulus sequencer stepping 0..LAST_PATTERN, HOLD_CYCLES clocks each.
// Define PATTERN_SEQ_LOOP_EN to wrap back to pattern 0 forever instead of stopping.
module pattern_seq
    import pattern_seq_pkg::*;
#(
    parameter int HOLD_CYCLES  = 20,
    parameter int LAST_PATTERN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause,
    output logic                 in_1,
    output logic                 in_2,
    output logic                 in_3,
    output logic [PATTERN_W-1:0] pattern_idx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [PATTERN_W-1:0] LAST_P = PATTERN_W'(LAST_PATTERN);

    state_e               state_q, state_d;
    logic [PATTERN_W-1:0] pattern_q, pattern_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 load;
    logic                 timer_en;
    logic                 expire;

    assign timer_en = (state_q == HOLD) && !pause;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .en_i    (timer_en),
        .expire_o(expire)
    );

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = HOLD;
                    pattern_d = '0;
                    busy_d    = 1'b1;
                    load      = 1'b1;
                end
            end
            HOLD: begin
                // Pause is checked first so it overrides an expiring counter.
                if (!pause && expire) begin
                    if (pattern_q != LAST_P) begin
                        pattern_d = pattern_q + 1'b1;
                        load      = 1'b1;
                    end else begin
`ifdef PATTERN_SEQ_LOOP_EN
                        pattern_d = '0;
                        load      = 1'b1;
                        done_d    = 1'b1;
`else
                        state_d   = IDLE;
                        pattern_d = '0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign in_1        = pattern_q[0];
    assign in_2        = pattern_q[1];
    assign in_3        = pattern_q[2];
    assign pattern_idx = pattern_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pattern_seq.sv
// Self-checking bench for pattern_seq: (20,4) and (1,7) instances against an elapsed-time model.
module tb_pattern_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s[2];
    logic       start_s[2];
    logic       pause_s[2];
    logic       in1_w[2], in2_w[2], in3_w[2];
    logic [2:0] pat_w[2];
    logic       busy_w[2];
    logic       done_w[2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    pattern_seq #(.HOLD_CYCLES(20), .LAST_PATTERN(4)) dut_a (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .pause(pause_s[0]),
        .in_1(in1_w[0]), .in_2(in2_w[0]), .in_3(in3_w[0]),
        .pattern_idx(pat_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    pattern_seq #(.HOLD_CYCLES(1), .LAST_PATTERN(7)) dut_b (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .pause(pause_s[1]),
        .in_1(in1_w[1]), .in_2(in2_w[1]), .in_3(in3_w[1]),
        .pattern_idx(pat_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    function automatic int hc(input int i);
        return (i == 0) ? 20 : 1;
    endfunction

    function automatic int lp(input int i);
        return (i == 0) ? 4 : 7;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is a count of unpaused cycles since start; pattern = elapsed / hold.
    bit act_m[2];
    int t_m[2];
    bit done_m[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            act_m[i] = 1'b0; t_m[i] = 0; done_m[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic int nt;
            if (rst_s[i]) begin
                act_m[i] <= 1'b0; t_m[i] <= 0; done_m[i] <= 1'b0;
            end else if (!act_m[i]) begin
                done_m[i] <= 1'b0;
                if (start_s[i]) begin
                    act_m[i] <= 1'b1; t_m[i] <= 0;
                end
            end else begin
                nt = t_m[i] + (pause_s[i] ? 0 : 1);
                if (nt == (lp(i) + 1) * hc(i)) begin
                    done_m[i] <= 1'b1;
                    t_m[i]    <= 0;
`ifndef PATTERN_SEQ_LOOP_EN
                    act_m[i]  <= 1'b0;
`endif
                end else begin
                    done_m[i] <= 1'b0;
                    t_m[i]    <= nt;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                automatic int ep = act_m[i] ? (t_m[i] / hc(i)) : 0;
                chk($sformatf("model_busy[%0d]", i), int'(busy_w[i]), int'(act_m[i]));
                chk($sformatf("model_done[%0d]", i), int'(done_w[i]), int'(done_m[i]));
                chk($sformatf("model_pattern[%0d]", i), int'(pat_w[i]), ep);
                chk($sformatf("model_inbits[%0d]", i), int'({in3_w[i], in2_w[i], in1_w[i]}), ep);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // Start a run on instance A, optionally pausing / poking start, and measure it.
    task automatic run_a(input int pause_at, input int pause_len, input int start_at,
                         output int done_idx, output int busy_cnt, output int p2cnt);
        int idx;
        start_s[0] = 1'b1;
        cyc();
        start_s[0] = 1'b0;
        idx = 0; busy_cnt = 0; p2cnt = 0; done_idx = -1;
        while (idx < 300) begin
            if (done_w[0] === 1'b1) begin
                done_idx = idx;
                break;
            end
            if (busy_w[0] === 1'b1) busy_cnt++;
            if (busy_w[0] === 1'b1 && pat_w[0] == 3'd2) p2cnt++;
            pause_s[0] = (idx >= pause_at) && (idx < pause_at + pause_len);
            start_s[0] = (idx == start_at);
            cyc();
            idx++;
        end
        pause_s[0] = 1'b0;
        start_s[0] = 1'b0;
    endtask

    initial begin
        int d, b, p, n, dn;
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b1; start_s[i] = 1'b0; pause_s[i] = 1'b0;
        end
        repeat (3) cyc();
        for (int i = 0; i < 2; i++) rst_s[i] = 1'b0;
        chk_en = 1'b1;
        cyc();
        chk("reset_busy", int'(busy_w[0]), 0);
        chk("reset_done", int'(done_w[0]), 0);
        chk("reset_pattern", int'(pat_w[0]), 0);

        run_a(-1, 0, -1, d, b, p);
        chk("plain_done_cycle", d, 100);
        chk("plain_busy_cycles", b, 100);
        chk("plain_p2_cycles", p, 20);

`ifndef PATTERN_SEQ_LOOP_EN
        cyc();
        run_a(45, 7, -1, d, b, p);
        chk("pause_done_cycle", d, 107);
        chk("pause_p2_cycles", p, 27);

        cyc();
        run_a(-1, 0, 65, d, b, p);
        chk("busy_start_done_cycle", d, 100);
        // start in the done cycle is accepted
        start_s[0] = 1'b1;
        cyc();
        start_s[0] = 1'b0;
        chk("restart_busy", int'(busy_w[0]), 1);
        chk("restart_pattern", int'(pat_w[0]), 0);
        repeat (65) cyc();
        chk("pre_rst_pattern", int'(pat_w[0]), 3);
        rst_s[0] = 1'b1;
        cyc();
        rst_s[0] = 1'b0;
        chk("midrst_busy", int'(busy_w[0]), 0);
        chk("midrst_pattern", int'(pat_w[0]), 0);
        dn = 0;
        for (int k = 0; k < 60; k++) begin
            if (done_w[0] === 1'b1) dn++;
            cyc();
        end
        chk("midrst_no_done", dn, 0);
        run_a(-1, 0, -1, d, b, p);
        chk("after_rst_done_cycle", d, 100);
`else
        n = -1;
        for (int k = 1; k <= 300; k++) begin
            cyc();
            if (done_w[0] === 1'b1) begin
                n = k;
                break;
            end
        end
        chk("loop_done_period", n, 100);
        chk("loop_busy_kept", int'(busy_w[0]), 1);
        rst_s[0] = 1'b1;
        cyc();
        rst_s[0] = 1'b0;
        chk("loop_rst_busy", int'(busy_w[0]), 0);
`endif

        // Instance B: one cycle per pattern, patterns 0..7
        cyc();
        start_s[1] = 1'b1;
        cyc();
        start_s[1] = 1'b0;
        n = -1;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) chk("b_pattern_at_3", int'(pat_w[1]), 3);
            if (k == 7) chk("b_pattern_at_7", int'(pat_w[1]), 7);
            if (done_w[1] === 1'b1) begin
                n = k;
                break;
            end
            cyc();
        end
        chk("b_done_cycle", n, 8);
        repeat (4) cyc();
        rst_s[1] = 1'b1;
        cyc();
        rst_s[1] = 1'b0;
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
